fetch_stage_sramlike: RTL and testbench
=======================================

Name: fetch_stage_sramlike

Overview:
Parametrised instruction-fetch stage driving a split request/response (SRAM-like) instruction port.
- Multiple outstanding requests; responses are in order.
- Small instruction buffer decouples fetch from decode backpressure.
- Redirect (exception, ertn, branch) cancels in-flight requests by discarding their late responses.
- Sits between the PC/redirect sources and the decode stage; delivers {inst, pc, adef} to decode.

Parameters:
PC_W, 32, PC/address width
RESET_PC, 32'h1C00_0000, first fetch address after reset
IBUF_DEPTH, 4, instruction buffer entries (power of 2, ≥2)
MAX_OUTST, 2, maximum requests issued but not yet answered (≤IBUF_DEPTH)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2 (word)
inst_sram_addr  out  PC_W  fetch address
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  response valid this cycle
inst_sram_rdata  in  32  response data
ds_allowin  in  1  decode can accept
br_zip  in  PC_W+1  {br_taken, br_target}
wb_ex  in  1  exception redirect
ertn_flush  in  1  ertn redirect
ex_entry  in  PC_W  exception target
ertn_entry  in  PC_W  ertn target
fs2ds_valid  out  1  bus valid
fs2ds_bus  out  PC_W+33  {inst[31:0], pc, adef}

Behaviour:
- Clock domain: single clk; resetn is synchronous and active-low (fixed).
- Reset: fetch_pc=RESET_PC, inflight=0, discard=0, FIFO empty, halted=0. Outputs: req=0, fs2ds_valid=0.
- Redirect priority: wb_ex > ertn_flush > br_taken. redirect = OR of all three.
- Request issue: req = resetn & ~halted & ~redirect & pc[1:0]==0 & (inflight+fifo_count < IBUF_DEPTH) & inflight<MAX_OUTST.
  - addr = fetch_pc.
  - On req&addr_ok: fetch_pc += 4; push pc into pending-PC queue (depth MAX_OUTST); inflight += 1.
- Response: on data_ok, inflight -= 1 and the pending-PC queue pops.
  - If discard>0: discard -= 1, data dropped.
  - Otherwise push {rdata, pc, 0} into FIFO.
  - Issue and response in the same cycle: net inflight change 0.
- Misaligned PC (pc[1:0]≠0) with free FIFO slot and inflight==0:
  - Push {32'h0, pc, 1} into FIFO, no bus request.
  - Set halted=1 until the next redirect.
- Output: fs2ds_valid = FIFO non-empty & ~redirect. Pop when fs2ds_valid & ds_allowin. Push and pop in the same cycle are allowed.
- On redirect:
  - Flush FIFO.
  - Load fetch_pc = selected target.
  - halted=0.
  - discard = inflight − (data_ok & discard==0 ? 1 : 0) + discard-adjust: every outstanding response at the end of the cycle becomes discarded.
  - No request is issued in the redirect cycle.
  - A response in the redirect cycle is dropped.
- Redirect while discard>0: discard is recomputed as the total outstanding; it never double counts.
- FIFO full: req held low. addr_ok arriving while req is low is ignored.
- Latency: addr_ok at cycle t and data_ok at t+1 give fs2ds_valid at t+2.

Optional Feature:
FS_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] (entries popped to decode) and perf_cancel_cnt[31:0] (responses discarded). Both are wrapping counters, reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared package fs_pkg: bus width constant FS2DS_W=PC_W+33, RESET_PC default, size encoding constants.
- One sub-module: fs_sync_fifo (parametrised width/depth, count output, flush input).
  - Instantiated for the instruction buffer and the pending-PC queue.

Test Plan:
- Reset release, addr_ok=1, data_ok one cycle later, ds_allowin=1 → addresses 1C000000, 1C000004, …; bus pcs match, adef=0.
- ds_allowin=0 for 10 cycles, IBUF_DEPTH=4 → exactly 4 entries buffered; req low; on release, pcs delivered in order without loss.
- Two requests outstanding, then br_taken to 1C000100 → both late responses dropped (perf_cancel_cnt=2); next delivered pc=1C000100.
- wb_ex and br_taken in the same cycle → fetch resumes at ex_entry.
- br_target=1C000102 → one entry {0, 1C000102, adef=1}, no bus req until ertn_flush to 1C000200.
- data_ok and redirect in the same cycle with 1 outstanding → 0 entries pushed; discard count correct; no stale instruction delivered.

Source files
------------

// File: rtl/fetch_stage_sramlike_pkg.sv
// Shared constants for the SRAM-like instruction fetch stage: widths,
// reset PC default and transfer-size encodings.
package fs_pkg;

    localparam int unsigned FS_PC_W     = 32;
    localparam int unsigned FS2DS_W     = FS_PC_W + 33;
    localparam logic [31:0] FS_RESET_PC = 32'h1C00_0000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Decode bus layout is {inst[31:0], pc, adef}.
    function automatic int unsigned fs2ds_width(input int unsigned pc_w);
        return pc_w + 33;
    endfunction

endpackage

// File: rtl/fetch_stage_sramlike_if.sv
// Instruction-port and decode-side handshake bundle for the fetch stage.
// master = fetch stage, slave = memory/decode environment.
interface fetch_stage_sramlike_if #(
    parameter int unsigned PC_W = 32
);
    logic              inst_sram_req;
    logic              inst_sram_wr;
    logic [1:0]        inst_sram_size;
    logic [PC_W-1:0]   inst_sram_addr;
    logic              inst_sram_addr_ok;
    logic              inst_sram_data_ok;
    logic [31:0]       inst_sram_rdata;
    logic              ds_allowin;
    logic              fs2ds_valid;
    logic [PC_W+32:0]  fs2ds_bus;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output fs2ds_valid, fs2ds_bus,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  ds_allowin
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  fs2ds_valid, fs2ds_bus,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output ds_allowin
    );
endinterface

// File: rtl/fetch_stage_sramlike_fifo.sv
// fs_sync_fifo: synchronous FIFO with occupancy count and flush, used for
// both the instruction buffer and the pending-PC queue.
module fs_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage_sramlike.sv
// Instruction fetch stage on a split request/response instruction port with
// in-order outstanding requests, an instruction buffer and redirect cancel.
// Optional FS_PERF_CNT_EN adds perf_fetch_cnt / perf_cancel_cnt outputs.
module fetch_stage_sramlike
    import fs_pkg::*;
#(
    parameter int unsigned     PC_W       = FS_PC_W,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(FS_RESET_PC),
    parameter int unsigned     IBUF_DEPTH = 4,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    fetch_stage_sramlike_if.master bus,
    input  logic [PC_W:0]          br_zip,
    input  logic                   wb_ex,
    input  logic                   ertn_flush,
    input  logic [PC_W-1:0]        ex_entry,
    input  logic [PC_W-1:0]        ertn_entry
`ifdef FS_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_cancel_cnt
`endif
);

    localparam int unsigned BUS_W    = fs2ds_width(PC_W);
    localparam int unsigned IB_CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned PQ_CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW       = IB_CNT_W + 1;

    logic                br_taken;
    logic [PC_W-1:0]     br_target;
    logic                redirect;
    logic [PC_W-1:0]     redirect_pc;

    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic                halted_q, halted_d;
    logic [CW-1:0]       discard_q, discard_d;

    logic [IB_CNT_W-1:0] ib_count;
    logic                ib_empty, ib_full;
    logic                ib_push, ib_pop;
    logic [BUS_W-1:0]    ib_wdata, ib_rdata;

    logic [PQ_CNT_W-1:0] pq_count;
    logic                pq_empty, pq_full;
    logic [PC_W-1:0]     pq_rdata;

    logic [CW-1:0]       inflight, ib_used;
    logic                pc_aligned;
    logic                req, issue;
    logic                rsp_vld, rsp_keep, adef_push;

    assign {br_taken, br_target} = br_zip;
    assign redirect = wb_ex | ertn_flush | br_taken;

    always_comb begin
        redirect_pc = br_target;
        if (wb_ex) begin
            redirect_pc = ex_entry;
        end else if (ertn_flush) begin
            redirect_pc = ertn_entry;
        end
    end

    assign inflight   = CW'(pq_count);
    assign ib_used    = CW'(ib_count);
    assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);

    // A request reserves a buffer slot for its response up front.
    assign req = resetn & ~halted_q & ~redirect & pc_aligned
               & ((inflight + ib_used) < CW'(IBUF_DEPTH)) & ~pq_full;
    assign issue = req & bus.inst_sram_addr_ok;

    assign rsp_vld   = bus.inst_sram_data_ok & ~pq_empty;
    assign rsp_keep  = rsp_vld & (discard_q == '0) & ~redirect;
    assign adef_push = ~redirect & ~halted_q & ~pc_aligned & pq_empty & ~ib_full;

    assign ib_push  = rsp_keep | adef_push;
    assign ib_wdata = adef_push ? {32'h0, fetch_pc_q, 1'b1}
                                : {bus.inst_sram_rdata, pq_rdata, 1'b0};

    assign bus.fs2ds_valid = ~ib_empty & ~redirect;
    assign bus.fs2ds_bus   = ib_rdata;
    assign ib_pop          = bus.fs2ds_valid & bus.ds_allowin;

    assign bus.inst_sram_req  = req;
    assign bus.inst_sram_wr   = 1'b0;
    assign bus.inst_sram_size = SIZE_WORD;
    assign bus.inst_sram_addr = fetch_pc_q;

    fs_sync_fifo #(
        .W     (BUS_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk    (clk),
        .resetn (resetn),
        .flush  (redirect),
        .push   (ib_push),
        .wdata  (ib_wdata),
        .pop    (ib_pop),
        .rdata  (ib_rdata),
        .count  (ib_count),
        .empty  (ib_empty),
        .full   (ib_full)
    );

    // Pending-PC queue is never flushed: cancelled responses still arrive
    // and must pop their PC to keep later responses aligned.
    fs_sync_fifo #(
        .W     (PC_W),
        .DEPTH (MAX_OUTST)
    ) u_pend_pc (
        .clk    (clk),
        .resetn (resetn),
        .flush  (1'b0),
        .push   (issue),
        .wdata  (fetch_pc_q),
        .pop    (rsp_vld),
        .rdata  (pq_rdata),
        .count  (pq_count),
        .empty  (pq_empty),
        .full   (pq_full)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            // Everything still outstanding after this cycle is stale.
            discard_d  = inflight - CW'(rsp_vld);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (adef_push) begin
                halted_d = 1'b1;
            end
            if (rsp_vld && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FS_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_cancel_q, perf_cancel_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q + 32'(ib_pop);
        perf_cancel_d = perf_cancel_q
                      + 32'(rsp_vld & ((discard_q != '0) | redirect));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_fetch_q  <= '0;
            perf_cancel_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_cancel_q <= perf_cancel_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_cancel_cnt = perf_cancel_q;
`endif

endmodule

// File: tb/tb_fetch_stage_sramlike.sv
// Directed bench for fetch_stage_sramlike: streaming, backpressure, redirect
// cancel, redirect priority, misaligned target and data_ok/redirect overlap.
`timescale 1ns/1ps
module tb_fetch_stage_sramlike;
    import fs_pkg::*;

    localparam int unsigned PC_W = 32;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fetch_stage_sramlike_if #(.PC_W(PC_W)) bus ();

    logic [PC_W:0]   br_zip;
    logic            wb_ex;
    logic            ertn_flush;
    logic [PC_W-1:0] ex_entry;
    logic [PC_W-1:0] ertn_entry;
`ifdef FS_PERF_CNT_EN
    logic [31:0]     perf_fetch_cnt;
    logic [31:0]     perf_cancel_cnt;
    logic [31:0]     cancel_base;
`endif

    fetch_stage_sramlike #(
        .PC_W       (PC_W),
        .RESET_PC   (BASE),
        .IBUF_DEPTH (4),
        .MAX_OUTST  (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .br_zip     (br_zip),
        .wb_ex      (wb_ex),
        .ertn_flush (ertn_flush),
        .ex_entry   (ex_entry),
        .ertn_entry (ertn_entry)
`ifdef FS_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_cancel_cnt (perf_cancel_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic dok_en;
    logic [31:0] rsp_q [$];

    // Memory model: in-order responses, instruction word = ~address.
    always @(negedge clk) begin
        if (!resetn) begin
            rsp_q.delete();
        end else begin
            if (bus.inst_sram_data_ok) void'(rsp_q.pop_front());
            if (bus.inst_sram_req && bus.inst_sram_addr_ok) rsp_q.push_back(bus.inst_sram_addr);
        end
    end

    always @(posedge clk) begin
        #2;
        bus.inst_sram_data_ok = dok_en && (rsp_q.size() != 0);
        bus.inst_sram_rdata   = (rsp_q.size() != 0) ? ~rsp_q[0] : 32'h0;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [64:0] ent(input logic [31:0] pc);
        return {~pc, pc, 1'b0};
    endfunction

    task automatic wait_valid(input string tag, input logic [64:0] exp);
        int n;
        n = 0;
        settle();
        while (!bus.fs2ds_valid && n < 20) begin
            cyc();
            settle();
            n++;
        end
        chk({tag, "_valid"}, 128'(bus.fs2ds_valid), 128'(1));
        chk(tag, 128'(bus.fs2ds_bus), 128'(exp));
    endtask

    initial begin
        resetn = 1'b0;
        dok_en = 1'b0;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'h0;
        bus.ds_allowin        = 1'b0;
        br_zip = '0; wb_ex = 1'b0; ertn_flush = 1'b0;
        ex_entry = '0; ertn_entry = '0;

        repeat (3) cyc();
        bus.inst_sram_addr_ok = 1'b1;
        settle();
        chk("rst_req",   128'(bus.inst_sram_req), 128'(0));
        chk("rst_valid", 128'(bus.fs2ds_valid),   128'(0));

        // Streaming: addr_ok every cycle, data one cycle later.
        cyc();
        resetn = 1'b1; dok_en = 1'b1; bus.ds_allowin = 1'b1;
        settle();
        chk("wr",   128'(bus.inst_sram_wr),   128'(0));
        chk("size", 128'(bus.inst_sram_size), 128'(2));
        for (int j = 0; j < 6; j++) begin
            if (j > 0) begin cyc(); settle(); end
            chk("a_req",  128'(bus.inst_sram_req),  128'(1));
            chk("a_addr", 128'(bus.inst_sram_addr), 128'(BASE + 32'(4 * j)));
            if (j >= 2) begin
                chk("a_valid", 128'(bus.fs2ds_valid), 128'(1));
                chk("a_bus",   128'(bus.fs2ds_bus),   128'(ent(BASE + 32'(4 * (j - 2)))));
            end else begin
                chk("a_novalid", 128'(bus.fs2ds_valid), 128'(0));
            end
        end

        // Backpressure for 10 cycles: buffer fills to 4, req drops.
        cyc(); bus.ds_allowin = 1'b0; settle();
        chk("b_req6",  128'(bus.inst_sram_req),  128'(1));
        chk("b_addr6", 128'(bus.inst_sram_addr), 128'(BASE + 32'h18));
        chk("b_bus6",  128'(bus.fs2ds_bus),      128'(ent(BASE + 32'h10)));
        cyc(); settle();
        chk("b_req7",  128'(bus.inst_sram_req),  128'(1));
        chk("b_addr7", 128'(bus.inst_sram_addr), 128'(BASE + 32'h1C));
        cyc(); settle();
        chk("b_req8", 128'(bus.inst_sram_req), 128'(0));
        repeat (7) cyc();
        settle();
        chk("b_req15",   128'(bus.inst_sram_req), 128'(0));
        chk("b_valid15", 128'(bus.fs2ds_valid),   128'(1));
        chk("b_bus15",   128'(bus.fs2ds_bus),     128'(ent(BASE + 32'h10)));
        cyc(); bus.ds_allowin = 1'b1; settle();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin cyc(); settle(); end
            chk("b_valid", 128'(bus.fs2ds_valid), 128'(1));
            chk("b_bus",   128'(bus.fs2ds_bus),   128'(ent(BASE + 32'h10 + 32'(4 * k))));
        end

        // Drain to a known PC before the cancel test.
        cyc(); bus.inst_sram_addr_ok = 1'b0; br_zip = {1'b1, BASE + 32'h40};
        cyc(); br_zip = '0;
        repeat (8) cyc();

        // Two outstanding, then branch to 1C000100.
        dok_en = 1'b0; bus.inst_sram_addr_ok = 1'b1; settle();
        chk("c_req0",  128'(bus.inst_sram_req),  128'(1));
        chk("c_addr0", 128'(bus.inst_sram_addr), 128'(BASE + 32'h40));
        chk("c_val0",  128'(bus.fs2ds_valid),    128'(0));
        cyc(); settle();
        chk("c_addr1", 128'(bus.inst_sram_addr), 128'(BASE + 32'h44));
        cyc(); settle();
        chk("c_req2", 128'(bus.inst_sram_req), 128'(0));
        cyc(); br_zip = {1'b1, BASE + 32'h100}; settle();
`ifdef FS_PERF_CNT_EN
        cancel_base = perf_cancel_cnt;
`endif
        chk("c_req3", 128'(bus.inst_sram_req), 128'(0));
        chk("c_val3", 128'(bus.fs2ds_valid),   128'(0));
        cyc(); br_zip = '0; dok_en = 1'b1; settle();
        chk("c_req4", 128'(bus.inst_sram_req), 128'(0));
        chk("c_val4", 128'(bus.fs2ds_valid),   128'(0));
        cyc(); settle();
        chk("c_req5",  128'(bus.inst_sram_req),  128'(1));
        chk("c_addr5", 128'(bus.inst_sram_addr), 128'(BASE + 32'h100));
        chk("c_val5",  128'(bus.fs2ds_valid),    128'(0));
        cyc(); settle();
        chk("c_val6", 128'(bus.fs2ds_valid), 128'(0));
        cyc(); settle();
        chk("c_val7", 128'(bus.fs2ds_valid), 128'(1));
        chk("c_bus7", 128'(bus.fs2ds_bus),   128'(ent(BASE + 32'h100)));
`ifdef FS_PERF_CNT_EN
        chk("c_cancel", 128'(perf_cancel_cnt - cancel_base), 128'(2));
`endif

        // wb_ex and br_taken together: exception target wins.
        cyc(); wb_ex = 1'b1; ex_entry = BASE + 32'h800; br_zip = {1'b1, BASE + 32'h300}; settle();
        chk("d_req", 128'(bus.inst_sram_req), 128'(0));
        chk("d_val", 128'(bus.fs2ds_valid),   128'(0));
        cyc(); wb_ex = 1'b0; br_zip = '0;
        wait_valid("d_pc", ent(BASE + 32'h800));

        // Misaligned branch target: one adef entry, then halted.
        cyc(); br_zip = {1'b1, BASE + 32'h102}; settle();
        chk("e_req_rd", 128'(bus.inst_sram_req), 128'(0));
        cyc(); br_zip = '0;
        wait_valid("e_adef", {32'h0, BASE + 32'h102, 1'b1});
        for (int k = 0; k < 3; k++) begin
            cyc(); settle();
            chk("e_halt_req", 128'(bus.inst_sram_req), 128'(0));
            chk("e_halt_val", 128'(bus.fs2ds_valid),   128'(0));
        end
        cyc(); ertn_flush = 1'b1; ertn_entry = BASE + 32'h200; settle();
        cyc(); ertn_flush = 1'b0;
        wait_valid("e_ertn", ent(BASE + 32'h200));

        // data_ok coincides with a redirect while one request is outstanding.
        cyc(); bus.inst_sram_addr_ok = 1'b0;
        repeat (8) cyc();
        bus.inst_sram_addr_ok = 1'b1; settle();
        chk("f_req0", 128'(bus.inst_sram_req), 128'(1));
        chk("f_val0", 128'(bus.fs2ds_valid),   128'(0));
        cyc(); bus.inst_sram_addr_ok = 1'b0; br_zip = {1'b1, BASE + 32'h400}; settle();
        chk("f_val1", 128'(bus.fs2ds_valid),   128'(0));
        chk("f_req1", 128'(bus.inst_sram_req), 128'(0));
        cyc(); br_zip = '0; bus.inst_sram_addr_ok = 1'b1; settle();
        chk("f_req2",  128'(bus.inst_sram_req),  128'(1));
        chk("f_addr2", 128'(bus.inst_sram_addr), 128'(BASE + 32'h400));
        chk("f_val2",  128'(bus.fs2ds_valid),    128'(0));
        cyc(); settle();
        chk("f_val3", 128'(bus.fs2ds_valid), 128'(0));
        cyc(); settle();
        chk("f_val4", 128'(bus.fs2ds_valid), 128'(1));
        chk("f_bus4", 128'(bus.fs2ds_bus),   128'(ent(BASE + 32'h400)));

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
